// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding and default collision geometry used by the display stage.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } gstate_e;

    localparam int COORD_W     = 10;
    localparam int DINO_XL_DEF = 80;
    localparam int DINO_XR_DEF = 110;
    localparam int BLK_W_DEF   = 20;
    localparam int BLK_TOP_DEF = 420;

    // Right edge is formed in 11 bits so a block near x=1023 cannot wrap into the dino window.
    function automatic logic hit_test(input logic [COORD_W-1:0] bx,
                                      input logic [COORD_W-1:0] dy,
                                      input int xl, input int xr,
                                      input int w,  input int top);
        logic [COORD_W:0] right;
        right = {1'b0, bx} + (COORD_W+1)'(w);
        return (bx < COORD_W'(xr)) && (right > (COORD_W+1)'(xl)) && (dy > COORD_W'(top));
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debounce (GAME_CTRL_DEBOUNCE_EN), registered press pulse.
// Press pulse lands 3 cycles after the raw edge without debounce, 2+DB_CYC cycles with it.
module btn_cond #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic sync0_q, sync1_q;
    logic level_q, level_d;
    logic press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync1_q != level_q) begin
            if (cnt_q == CW'(DB_CYC - 1)) begin
                level_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_db;

    assign level_d   = sync1_q;
    assign unused_db = (DB_CYC == 0);
`endif

    assign press_o = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Game FSM (IDLE/RUN/OVER) with registered collision detect and restart hold-off; debounce via GAME_CTRL_DEBOUNCE_EN.
// jump/re_start are single-cycle pulses driven in the cycle the conditioned press is seen.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DB_CYC   = 1_000_000,
    parameter int HOLD_CYC = 10_000_000,
    parameter int DINO_XL  = DINO_XL_DEF,
    parameter int DINO_XR  = DINO_XR_DEF,
    parameter int BLK_W    = BLK_W_DEF,
    parameter int BLK_TOP  = BLK_TOP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_jump,
    input  logic               btn_start,
    input  logic [COORD_W-1:0] dinosaur_Y,
    input  logic [COORD_W-1:0] block_X,
    output logic               jump,
    output logic               re_start,
    output logic               isover,
    output logic [1:0]         gstate
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    logic          jump_press, start_press;
    gstate_e       state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          hit_q, hit_d;
    logic          mask_q;
    logic          jump_c, restart_c;

    btn_cond #(.DB_CYC(DB_CYC)) u_jump_cond (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_jump),
        .press_o (jump_press)
    );

    btn_cond #(.DB_CYC(DB_CYC)) u_start_cond (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_start),
        .press_o (start_press)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        jump_c    = 1'b0;
        restart_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_press) begin
                    restart_c = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Collision outranks a same-cycle jump press.
                if (hit_q) begin
                    state_d = OVER;
                    hold_d  = '0;
                end else if (jump_press) begin
                    jump_c = 1'b1;
                end
            end
            OVER: begin
                if (start_press && (hold_q == HW'(HOLD_CYC))) begin
                    restart_c = 1'b1;
                    state_d   = RUN;
                end else if (hold_q != HW'(HOLD_CYC)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stale coordinates from the previous game are ignored for two cycles around a restart.
    assign hit_d = (restart_c || mask_q) ? 1'b0
                 : hit_test(block_X, dinosaur_Y, DINO_XL, DINO_XR, BLK_W, BLK_TOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            hit_q   <= 1'b0;
            mask_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hit_q   <= hit_d;
            mask_q  <= restart_c;
        end
    end

    assign jump     = jump_c & ~rst;
    assign re_start = restart_c & ~rst;
    assign isover   = (state_q != RUN);
    assign gstate   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vectors and sequences plus randomized stimulus against a cycle-level reference model.
module tb_game_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 8;
`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif
    localparam int ST_I = 0;
    localparam int ST_R = 1;
    localparam int ST_O = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_jump = 1'b0;
    logic       btn_start = 1'b0;
    logic [9:0] dinosaur_Y = 10'd300;
    logic [9:0] block_X = 10'd500;
    logic       jump, re_start, isover;
    logic [1:0] gstate;

    game_ctrl #(
        .DB_CYC   (DB),
        .HOLD_CYC (HOLD),
        .DINO_XL  (80),
        .DINO_XR  (110),
        .BLK_W    (20),
        .BLK_TOP  (420)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_jump   (btn_jump),
        .btn_start  (btn_start),
        .dinosaur_Y (dinosaur_Y),
        .block_X    (block_X),
        .jump       (jump),
        .re_start   (re_start),
        .isover     (isover),
        .gstate     (gstate)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int jump_cnt = 0;

    // Reference model: state after the most recent edge.
    int        mstate = ST_I;
    int        mhold = 0;
    bit        mhit = 1'b0, mmask = 1'b0, mjp = 1'b0, msp = 1'b0;
    bit        jlev = 1'b0, slev = 1'b0;
    bit [15:0] jh = '0, sh = '0;

    typedef struct {
        int bx;
        int dy;
        bit over;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit geom(input int bx, input int dy);
        return (bx < 110) && (bx + 20 > 80) && (dy > 420);
    endfunction

    // h[0] is the raw sample taken at this edge; h[2] is what the second sync flop presented to it.
    function automatic bit next_level(input bit [15:0] h, input bit lev);
`ifdef GAME_CTRL_DEBOUNCE_EN
        for (int k = 0; k < DB; k++) begin
            if (h[2+k] == lev) return lev;
        end
        return ~lev;
`else
        return h[2];
`endif
    endfunction

    function automatic bit m_re();
        return msp && (mstate == ST_I || (mstate == ST_O && mhold == HOLD));
    endfunction

    function automatic bit m_jump();
        return (mstate == ST_R) && mjp && !mhit;
    endfunction

    task automatic model_step();
        bit re, nhit, nj, ns_l;
        int ns, nh;
        if (rst) begin
            mstate = ST_I; mhold = 0; mhit = 0; mmask = 0; mjp = 0; msp = 0;
            jlev = 0; slev = 0; jh = '0; sh = '0;
            return;
        end
        re = m_re();
        ns = mstate;
        nh = mhold;
        case (mstate)
            ST_I: if (msp) ns = ST_R;
            ST_R: if (mhit) begin ns = ST_O; nh = 0; end
            ST_O: begin
                if (re) ns = ST_R;
                else if (mhold < HOLD) nh = mhold + 1;
            end
            default: ns = ST_I;
        endcase
        nhit   = (re || mmask) ? 1'b0 : geom(int'(block_X), int'(dinosaur_Y));
        mmask  = re;
        mstate = ns;
        mhold  = nh;
        mhit   = nhit;
        jh     = {jh[14:0], btn_jump};
        sh     = {sh[14:0], btn_start};
        nj     = next_level(jh, jlev);
        ns_l   = next_level(sh, slev);
        mjp    = nj & ~jlev;
        msp    = ns_l & ~slev;
        jlev   = nj;
        slev   = ns_l;
    endtask

    task automatic tick();
        logic [4:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_jump(), m_re(), (mstate != ST_R), 2'(mstate)};
        chk("outputs_vs_model", {27'd0, jump, re_start, isover, gstate}, {27'd0, exp});
        if (re_start === 1'b1) re_cnt++;
        if (jump === 1'b1) jump_cnt++;
    endtask

    task automatic start_game();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        btn_start = 1'b1;
        repeat (LAT + 1) tick();
        btn_start = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    initial begin
        vec_t vecs[9];
        int   first;

        vecs[0] = '{95,   450, 1'b1};
        vecs[1] = '{95,   400, 1'b0};
        vecs[2] = '{109,  450, 1'b1};
        vecs[3] = '{110,  450, 1'b0};
        vecs[4] = '{61,   450, 1'b1};
        vecs[5] = '{60,   450, 1'b0};
        vecs[6] = '{95,   421, 1'b1};
        vecs[7] = '{95,   420, 1'b0};
        vecs[8] = '{1023, 450, 1'b0};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_gstate", gstate, ST_I);
        chk("reset_isover", isover, 1);
        chk("reset_jump", jump, 0);
        chk("reset_re_start", re_start, 0);
        rst = 1'b0;

        // Start from IDLE with a long press
        re_cnt = 0;
        btn_start = 1'b1;
        repeat (10) tick();
        chk("start_re_start_pulses", re_cnt, 1);
        chk("start_gstate_run", gstate, ST_R);
        chk("start_isover_low", isover, 0);
        btn_start = 1'b0;
        repeat (LAT + 2) tick();

        // Jump press (with bounce preamble when debouncing)
        jump_cnt = 0;
`ifdef GAME_CTRL_DEBOUNCE_EN
        for (int i = 0; i < 12; i++) begin
            btn_jump = ((i / 2) % 2) == 0;
            tick();
        end
        chk("bounce_no_jump", jump_cnt, 0);
`endif
        btn_jump = 1'b1;
        first = -1;
        for (int i = 1; i <= LAT + 6; i++) begin
            tick();
            if (jump === 1'b1 && first < 0) first = i;
        end
        chk("jump_pulse_count", jump_cnt, 1);
        chk("jump_pulse_latency", first, LAT);
        btn_jump = 1'b0;
        repeat (LAT + 2) tick();
        chk("jump_stays_run", gstate, ST_R);

        // Collision geometry table
        foreach (vecs[i]) begin
            start_game();
            block_X    = 10'(vecs[i].bx);
            dinosaur_Y = 10'(vecs[i].dy);
            tick();
            tick();
            chk($sformatf("collide_gstate_%0d", i), gstate, vecs[i].over ? ST_O : ST_R);
            chk($sformatf("collide_isover_%0d", i), isover, vecs[i].over ? 1 : 0);
            block_X    = 10'd500;
            dinosaur_Y = 10'd300;
        end

        // Hold-off in OVER: early press discarded and not queued, late press restarts
        start_game();
        block_X = 10'd95;
        dinosaur_Y = 10'd450;
        tick();
        tick();
        chk("hold_enter_over", gstate, ST_O);
        block_X = 10'd500;
        dinosaur_Y = 10'd300;
        re_cnt = 0;
        btn_start = 1'b1;
        repeat (LAT) tick();
        chk("hold_early_press_ignored", re_start, 0);
        repeat (12) tick();
        chk("hold_press_not_queued", re_cnt, 0);
        chk("hold_still_over", gstate, ST_O);
        btn_start = 1'b0;
        repeat (LAT + 2) tick();
        btn_start = 1'b1;
        repeat (LAT) tick();
        chk("hold_late_press_restart", re_start, 1);
        tick();
        chk("hold_restart_run", gstate, ST_R);
        chk("hold_restart_count", re_cnt, 1);
        btn_start = 1'b0;
        repeat (LAT + 2) tick();

        // Restart with colliding coordinates held throughout
        block_X = 10'd95;
        dinosaur_Y = 10'd450;
        tick();
        tick();
        chk("post_enter_over", gstate, ST_O);
        repeat (10) tick();
        btn_start = 1'b1;
        repeat (LAT) tick();
        chk("post_re_start", re_start, 1);
        tick();
        chk("post_masked_run_1", gstate, ST_R);
        tick();
        chk("post_masked_run_2", gstate, ST_R);
        tick();
        tick();
        chk("post_over_after_mask", gstate, ST_O);
        btn_start = 1'b0;
        block_X = 10'd500;
        dinosaur_Y = 10'd300;

        // Mid-game reset while a jump press is in flight
        start_game();
        chk("midrst_in_run", gstate, ST_R);
        jump_cnt = 0;
        re_cnt = 0;
        btn_jump = 1'b1;
        repeat (LAT - 1) tick();
        rst = 1'b1;
        tick();
        chk("midrst_gstate", gstate, ST_I);
        chk("midrst_isover", isover, 1);
        chk("midrst_jump", jump, 0);
        chk("midrst_re_start", re_start, 0);
        rst = 1'b0;
        repeat (LAT + 4) tick();
        chk("midrst_no_jump", jump_cnt, 0);
        chk("midrst_no_restart", re_cnt, 0);
        chk("midrst_stays_idle", gstate, ST_I);
        btn_jump = 1'b0;

        // Randomized run against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) btn_jump = ~btn_jump;
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1) block_X = 10'($urandom_range(55, 115));
                else block_X = 10'($urandom_range(0, 1023));
                dinosaur_Y = 10'($urandom_range(400, 460));
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DB_CYC, default 1_000_000, count of consecutive stable cycles required to accept a button level change.
REQ-002 Parameter HOLD_CYC, default 10_000_000, count of cycles in OVER before btn_start is honoured.
REQ-003 Parameters DINO_XL=80, DINO_XR=110, BLK_W=20, BLK_TOP=420 give the collision geometry in pixels.
REQ-004 clk  in  1  the single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 btn_jump  in  1  raw asynchronous jump button.
REQ-007 btn_start  in  1  raw asynchronous start/restart button.
REQ-008 dinosaur_Y  in  10  dinosaur bottom y-coordinate from the state register stage.
REQ-009 block_X  in  10  obstacle left x-coordinate from the state register stage.
REQ-010 jump  out  1  one-cycle pulse requesting a jump.
REQ-011 re_start  out  1  one-cycle pulse that restarts the state register stage.
REQ-012 isover  out  1  high while the game is frozen (IDLE or OVER).
REQ-013 gstate  out  2  current FSM state: IDLE=0, RUN=1, OVER=2.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser and then conditioning, producing a one-cycle press pulse on a 0->1 change of the accepted level.
REQ-015 hit SHALL be registered (1-cycle latency) as (block_X < DINO_XR) AND (block_X+BLK_W > DINO_XL) AND (dinosaur_Y > BLK_TOP), with the sum computed in 11 bits.
REQ-016 IDLE: isover=1; a start press SHALL assert re_start for exactly 1 cycle and enter RUN on the next cycle.
REQ-017 RUN: isover=0; a jump press SHALL assert jump for exactly 1 cycle; in any other state jump SHALL remain 0.
REQ-018 RUN: hit=1 SHALL enter OVER on the next cycle, clear the hold counter, and assert isover from that cycle onward.
REQ-019 Simultaneous hit and jump press in RUN: the transition to OVER SHALL win and jump SHALL remain 0.
REQ-020 OVER: the hold counter SHALL increment each cycle up to HOLD_CYC and saturate there; a start press while the count < HOLD_CYC SHALL be discarded, not queued.
REQ-021 OVER with the count == HOLD_CYC: a start press SHALL pulse re_start for 1 cycle and enter RUN.
REQ-022 A start press in RUN SHALL be ignored.
REQ-023 The hit register SHALL be forced to 0 on the cycle re_start is asserted and on the following cycle, so that stale coordinates cannot cause an immediate OVER.
REQ-024 State encoding value 3 SHALL recover to IDLE on the next cycle.

Reset
REQ-025 With rst=1 at a clock edge: gstate=IDLE, isover=1, jump=0, re_start=0, hit=0, all counters=0, synchroniser and accepted levels=0.
REQ-026 Reset during RUN or OVER SHALL abort the state immediately, and no re_start pulse SHALL be produced by the reset itself.

Configuration
REQ-027 Macro GAME_CTRL_DEBOUNCE_EN defined: the accepted level SHALL change only after the synchronised input differs from it for DB_CYC consecutive cycles; any glitch SHALL restart the count.
REQ-028 Macro GAME_CTRL_DEBOUNCE_EN undefined: the accepted level SHALL equal the synchronised input, so the press pulse occurs 3 cycles after the raw edge and DB_CYC is unused.

Structure
REQ-029 Package game_pkg SHALL hold the gstate enum (IDLE/RUN/OVER) and the geometry constants shared with the display stage.
REQ-030 Sub-module btn_cond (synchroniser, optional debounce, rising-edge pulse) SHALL be instantiated once per button.

Verification (bench uses DB_CYC=4, HOLD_CYC=8)
REQ-031 Start from reset: btn_start high for 10 cycles -> exactly one re_start pulse, gstate 0->1, isover 1->0.
REQ-032 Bounce: with the debounce macro defined, btn_jump toggled every 2 cycles for 12 cycles then held high -> exactly one jump pulse, arriving after 4 stable cycles.
REQ-033 Collision: in RUN, block_X=95 and dinosaur_Y=450 -> gstate=OVER and isover=1 two cycles later; with dinosaur_Y=400 -> no transition.
REQ-034 Hold: in OVER, a start press at hold count 3 -> no re_start; a press at count 8 -> re_start pulse and RUN.
REQ-035 Post-restart: block_X=95 and dinosaur_Y=450 held across a restart -> RUN persists for the 2 masked cycles, then OVER.
REQ-036 Mid-game reset: rst pulsed in RUN -> IDLE, isover=1, and no jump or re_start pulse.
